// File: rtl/turbo_interleaver_pkg.sv
// Shared constants, types and small helpers for the LTE QPP turbo interleaver.
package turbo_ilv_pkg;

  localparam int K_SHORT   = 1056;
  localparam int F1_S      = 17;
  localparam int F2_S      = 66;
  localparam int K_LONG    = 6144;
  localparam int F1_L      = 263;
  localparam int F2_L      = 480;
  localparam int MEM_DEPTH = K_LONG / 8;

  typedef logic [12:0] idx_t;
  typedef logic [9:0]  baddr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT
  } state_t;

  function automatic idx_t k_of(input logic sel);
    return sel ? idx_t'(K_LONG) : idx_t'(K_SHORT);
  endfunction

  function automatic baddr_t nbytes_of(input logic sel);
    return sel ? baddr_t'(K_LONG / 8) : baddr_t'(K_SHORT / 8);
  endfunction

  function automatic idx_t f1_of(input logic sel);
    return sel ? idx_t'(F1_L) : idx_t'(F1_S);
  endfunction

  function automatic idx_t f2_of(input logic sel);
    return sel ? idx_t'(F2_L) : idx_t'(F2_S);
  endfunction

  // (a + b) mod k for a, b < k: a 14-bit add followed by one conditional subtract.
  function automatic idx_t mod_add(input idx_t a, input idx_t b, input idx_t k);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[12:0];
  endfunction

endpackage

// File: rtl/turbo_interleaver_if.sv
// Byte-source and dual bit-stream signals of the turbo interleaver.
// master: the source/sink side; slave: the interleaver itself.
interface turbo_interleaver_if;

  logic [7:0] dataIn;
  logic       dataInNext;
  logic       flag_long_in;
  logic       look_now_in;
  logic       dataOut;
  logic       dataOut2;
  logic       flag_long_out;
  logic       look_now_out;

  modport master (
    output dataIn,
    output flag_long_in,
    output look_now_in,
    input  dataInNext,
    input  dataOut,
    input  dataOut2,
    input  flag_long_out,
    input  look_now_out
  );

  modport slave (
    input  dataIn,
    input  flag_long_in,
    input  look_now_in,
    output dataInNext,
    output dataOut,
    output dataOut2,
    output flag_long_out,
    output look_now_out
  );

endinterface

// File: rtl/turbo_interleaver_qpp_addr_gen.sv
// QPP address generator: PI(i) = (f1*i + f2*i*i) mod K, built from the
// first/second-difference recursion so no multiplier is needed.
// start loads PI(0)=0 and g(0)=(f1+f2) mod K; every other cycle advances one i.
module qpp_addr_gen
  import turbo_ilv_pkg::*;
(
  input  logic clk,
  input  logic reset_async,
  input  logic start,
  input  logic sel,
  output idx_t pi
);

  idx_t pi_q;
  idx_t g_q;
  idx_t k_cur;
  idx_t g_init;
  idx_t g_step;

  // Per-size constants of the recursion.
  always_comb begin
    k_cur  = k_of(sel);
    g_init = mod_add(f1_of(sel), f2_of(sel), k_cur);
    g_step = mod_add(f2_of(sel), f2_of(sel), k_cur);
  end

  // PI and its first difference g step together once per cycle.
  always_ff @(posedge clk) begin
    if (reset_async) begin
      pi_q <= '0;
      g_q  <= '0;
    end else if (start) begin
      pi_q <= '0;
      g_q  <= g_init;
    end else begin
      pi_q <= mod_add(pi_q, g_q, k_cur);
      g_q  <= mod_add(g_q, g_step, k_cur);
    end
  end

  assign pi = pi_q;

endmodule

// File: rtl/turbo_interleaver.sv
// LTE QPP turbo interleaver (K = 1056 or 6144).
// Loads one block as a byte stream, then emits the natural-order bit and the
// QPP-interleaved bit of every index, one index per cycle.
// Optional build macro: TURBO_ILV_LSB_FIRST_EN selects LSB-first bit order
// within each byte (default is MSB-first).
//
// state | meaning
// IDLE  | waiting for look_now_in; latches block size
// LOAD  | requesting K/8 bytes and writing them to both byte stores
// OUT   | issuing K read indices, then draining the 2-stage read pipeline
module turbo_interleaver
  import turbo_ilv_pkg::*;
(
  input  logic                clk,
  input  logic                reset_async,
  turbo_interleaver_if.slave  bus
);

  state_t     state_q;
  state_t     state_d;
  logic       sel_q;
  baddr_t     req_cnt_q;
  baddr_t     wr_addr_q;
  logic       wr_en_q;
  idx_t       out_cnt_q;
  idx_t       pi;
  logic       qpp_start;

  idx_t       k_cur;
  baddr_t     nbytes_cur;
  logic       req_active;
  logic       last_cap;
  logic       issue;
  logic       out_done;

  logic [7:0] mem_a [0:MEM_DEPTH-1];
  logic [7:0] mem_b [0:MEM_DEPTH-1];
  logic [7:0] rd_a_q;
  logic [7:0] rd_b_q;
  logic [2:0] bsel_a_q;
  logic [2:0] bsel_b_q;
  logic       v1_q;
  logic       dout_q;
  logic       dout2_q;
  logic       lno_q;
  logic       flo_q;

  // Position inside a stored byte of bit c[8n+b].
  function automatic logic [2:0] bit_pos(input logic [2:0] b);
`ifdef TURBO_ILV_LSB_FIRST_EN
    return b;
`else
    return 3'd7 - b;
`endif
  endfunction

  qpp_addr_gen u_qpp (
    .clk         (clk),
    .reset_async (reset_async),
    .start       (qpp_start),
    .sel         (sel_q),
    .pi          (pi)
  );

  // Block-size dependent limits and the per-cycle phase qualifiers.
  always_comb begin
    k_cur      = k_of(sel_q);
    nbytes_cur = nbytes_of(sel_q);
    req_active = (state_q == LOAD) && (req_cnt_q != nbytes_cur);
    last_cap   = (state_q == LOAD) && wr_en_q && (wr_addr_q == nbytes_cur - baddr_t'(1));
    issue      = (state_q == OUT) && (out_cnt_q < k_cur);
    out_done   = (state_q == OUT) && (out_cnt_q == k_cur + idx_t'(1));
  end

  // Next-state logic; the address generator is restarted as LOAD hands over to OUT.
  always_comb begin
    state_d   = state_q;
    qpp_start = 1'b0;
    case (state_q)
      IDLE: if (bus.look_now_in) state_d = LOAD;
      LOAD: begin
        if (last_cap) begin
          state_d   = OUT;
          qpp_start = 1'b1;
        end
      end
      OUT:  if (out_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_async) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Size latch, request counter, one-cycle-delayed capture strobe and output index.
  always_ff @(posedge clk) begin
    if (reset_async) begin
      sel_q     <= 1'b0;
      req_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      out_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && bus.look_now_in) sel_q <= bus.flag_long_in;
      if (state_q != LOAD)  req_cnt_q <= '0;
      else if (req_active)  req_cnt_q <= req_cnt_q + baddr_t'(1);
      wr_en_q   <= req_active;
      wr_addr_q <= req_cnt_q;
      if (state_q != OUT) out_cnt_q <= '0;
      else                out_cnt_q <= out_cnt_q + idx_t'(1);
    end
  end

  // Two identical byte stores, one per read port; synchronous reads.
  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      mem_a[wr_addr_q] <= bus.dataIn;
      mem_b[wr_addr_q] <= bus.dataIn;
    end
    if (issue) begin
      rd_a_q <= mem_a[out_cnt_q[12:3]];
      rd_b_q <= mem_b[pi[12:3]];
    end
  end

  // Read pipeline: bit selects follow the read data, then the registered outputs.
  always_ff @(posedge clk) begin
    if (reset_async) begin
      v1_q     <= 1'b0;
      bsel_a_q <= '0;
      bsel_b_q <= '0;
      dout_q   <= 1'b0;
      dout2_q  <= 1'b0;
      lno_q    <= 1'b0;
      flo_q    <= 1'b0;
    end else begin
      v1_q     <= issue;
      bsel_a_q <= out_cnt_q[2:0];
      bsel_b_q <= pi[2:0];
      lno_q    <= v1_q;
      dout_q   <= v1_q & rd_a_q[bit_pos(bsel_a_q)];
      dout2_q  <= v1_q & rd_b_q[bit_pos(bsel_b_q)];
      if (state_q == OUT) flo_q <= sel_q;
    end
  end

  assign bus.dataInNext    = req_active;
  assign bus.dataOut       = dout_q;
  assign bus.dataOut2      = dout2_q;
  assign bus.look_now_out  = lno_q;
  assign bus.flag_long_out = flo_q;

endmodule

// File: tb/tb_turbo_interleaver.sv
// Self-checking bench for turbo_interleaver: byte source model, direct-formula
// QPP reference, randomized block contents and look_now_in/flag_long_in noise.
module tb_turbo_interleaver;
  import turbo_ilv_pkg::*;

  logic clk = 1'b0;
  logic reset_async;
  always #5 clk = ~clk;

  turbo_interleaver_if bus();

  turbo_interleaver dut (
    .clk         (clk),
    .reset_async (reset_async),
    .bus         (bus)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] src [0:MEM_DEPTH-1];
  int         src_ptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int k_ref(input bit sel);
    return sel ? K_LONG : K_SHORT;
  endfunction

  function automatic int pi_ref(input bit sel, input int i);
    longint k, f1, f2, li;
    k  = sel ? K_LONG : K_SHORT;
    f1 = sel ? F1_L : F1_S;
    f2 = sel ? F2_L : F2_S;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  function automatic logic c_ref(input int i);
    logic [7:0] by;
    by = src[i / 8];
`ifdef TURBO_ILV_LSB_FIRST_EN
    return by[i % 8];
`else
    return by[7 - (i % 8)];
`endif
  endfunction

  // Advance one clock (negedge to negedge); the source answers a request on the same edge.
  task automatic step();
    logic r;
    r = bus.dataInNext;
    @(posedge clk);
    #1;
    if (r === 1'b1) begin
      bus.dataIn = src[src_ptr % MEM_DEPTH];
      src_ptr++;
    end
    @(negedge clk);
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {59'd0, bus.dataInNext, bus.dataOut, bus.dataOut2, bus.flag_long_out, bus.look_now_out}, 64'd0);
  endtask

  task automatic fill_random();
    for (int j = 0; j < MEM_DEPTH; j++) src[j] = 8'($urandom);
  endtask

  task automatic fill_zero();
    for (int j = 0; j < MEM_DEPTH; j++) src[j] = 8'h00;
  endtask

  // Runs one whole block from an IDLE negedge; returns at the first negedge with look_now_out low again.
  task automatic run_block(input string tag, input bit sel, input bit tog, output int ones1, output int ones2);
    int k, nb, budget, cyc, n_req, req_runs, req_fall, first_v, n_v, v_runs, b1, b2, bf;
    logic r, v, prev_r, prev_v, done, pi1_obs;
    k = k_ref(sel); nb = k / 8; budget = k + nb + 64;
    cyc = 0; n_req = 0; req_runs = 0; req_fall = -1; first_v = -1; n_v = 0; v_runs = 0;
    b1 = 0; b2 = 0; bf = 0; ones1 = 0; ones2 = 0;
    prev_r = 1'b0; prev_v = 1'b0; done = 1'b0; pi1_obs = 1'bx;
    src_ptr = 0;
    bus.flag_long_in = sel;
    bus.look_now_in  = 1'b1;
    step();
    chk({tag, "_req_start"}, bus.dataInNext, 1);
    while (!done && cyc < budget) begin
      r = bus.dataInNext;
      v = bus.look_now_out;
      if (r === 1'b1) begin
        n_req++;
        if (!prev_r) req_runs++;
      end else if (prev_r && req_fall < 0) req_fall = cyc;
      if (v === 1'b1) begin
        if (!prev_v) begin
          v_runs++;
          if (first_v < 0) first_v = cyc;
        end
        if (n_v < k) begin
          if (bus.dataOut !== c_ref(n_v)) b1++;
          if (bus.dataOut2 !== c_ref(pi_ref(sel, n_v))) b2++;
          if (bus.flag_long_out !== sel) bf++;
          if (bus.dataOut === 1'b1) ones1++;
          if (bus.dataOut2 === 1'b1) ones2++;
          if (n_v == 1) pi1_obs = bus.dataOut2;
        end
        n_v++;
      end else if (prev_v) done = 1'b1;
      prev_r = r;
      prev_v = v;
      if (!done) begin
        if (tog && n_v < k) begin
          bus.look_now_in  = 1'($urandom_range(0, 1));
          bus.flag_long_in = 1'($urandom_range(0, 1));
        end else begin
          bus.look_now_in  = 1'b0;
          bus.flag_long_in = sel;
        end
        step();
        cyc++;
      end
    end
    chk({tag, "_finished"}, done, 1);
    chk({tag, "_req_count"}, n_req, nb);
    chk({tag, "_req_runs"}, req_runs, 1);
    chk({tag, "_latency"}, first_v - req_fall, 3);
    chk({tag, "_valid_len"}, n_v, k);
    chk({tag, "_valid_runs"}, v_runs, 1);
    chk({tag, "_dout_bad"}, b1, 0);
    chk({tag, "_dout2_bad"}, b2, 0);
    chk({tag, "_flag_bad"}, bf, 0);
    chk({tag, "_pi1_bit"}, pi1_obs, c_ref(pi_ref(sel, 1)));
  endtask

  initial begin
    int o1, o2, w;
    bus.dataIn       = 8'h00;
    bus.look_now_in  = 1'b0;
    bus.flag_long_in = 1'b0;
    reset_async      = 1'b1;
    fill_zero();
    @(negedge clk);
    repeat (3) step();
    outs_zero("reset");
    reset_async = 1'b0;
    step();
    outs_zero("idle");

    // Short block, only byte 0 set.
    fill_zero();
    src[0] = 8'hFF;
    run_block("short_ff", 1'b0, 1'b0, o1, o2);
    chk("short_ff_dout_ones", o1, 8);
    chk("short_ff_dout2_ones", o2, 8);

    // Long block, only the last byte's LSB set.
    fill_zero();
    src[MEM_DEPTH-1] = 8'h01;
    run_block("long_last", 1'b1, 1'b0, o1, o2);
    chk("long_last_dout_ones", o1, 1);
    chk("long_last_dout2_ones", o2, 1);
    chk("long_last_flag_out", bus.flag_long_out, 1);

    // Random content with look_now_in / flag_long_in noise after the start.
    fill_random();
    run_block("short_rnd_tog", 1'b0, 1'b1, o1, o2);
    fill_random();
    run_block("long_rnd_tog", 1'b1, 1'b1, o1, o2);

    // Back-to-back: short then long with no gap.
    fill_random();
    run_block("b2b_short", 1'b0, 1'b0, o1, o2);
    fill_random();
    run_block("b2b_long", 1'b1, 1'b0, o1, o2);

    // Reset in the middle of LOAD.
    fill_random();
    src_ptr = 0;
    bus.flag_long_in = 1'b1;
    bus.look_now_in  = 1'b1;
    step();
    bus.look_now_in = 1'b0;
    repeat (50) step();
    chk("rst_load_reached", bus.dataInNext, 1);
    reset_async = 1'b1;
    step();
    outs_zero("rst_load");
    reset_async = 1'b0;
    repeat (5) step();
    outs_zero("rst_load_idle");
    fill_random();
    run_block("after_rst_load", 1'b0, 1'b0, o1, o2);

    // Reset in the middle of OUT on a long block.
    fill_random();
    src_ptr = 0;
    bus.flag_long_in = 1'b1;
    bus.look_now_in  = 1'b1;
    step();
    bus.look_now_in = 1'b0;
    w = 0;
    while (bus.look_now_out !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    chk("rst_out_reached", bus.look_now_out, 1);
    repeat (100) step();
    reset_async = 1'b1;
    step();
    outs_zero("rst_out");
    reset_async = 1'b0;
    repeat (5) step();
    outs_zero("rst_out_idle");
    fill_random();
    run_block("after_rst_out", 1'b1, 1'b0, o1, o2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
